// File: rtl/mouse_transmitter.sv
// Host-to-device PS/2 command transmitter: request-to-send, 11-bit frame out, ack check.
// Drives only open-drain enables/values; the enclosing transceiver owns the pads.
module mouse_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    output logic       CLK_MOUSE_OUT_EN,
    output logic       DATA_MOUSE_OUT,
    output logic       DATA_MOUSE_OUT_EN,
    input  logic       SEND_BYTE,
    input  logic [7:0] BYTE_TO_SEND,
    output logic       BUSY,
    output logic       BYTE_SENT,
    output logic       ERROR,
    output logic [2:0] fsm_state
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] START_LAST   = CW'(1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic          data_bit;
    logic          byte_sent_q;
    logic          error_q;

    logic clk_meta;
    logic clk_sync;
    logic clk_prev;
    logic data_meta;
    logic data_sync;
    logic fe;

    assign fe = clk_prev & ~clk_sync;

    // A request landing in the completion-pulse cycle is deliberately dropped.
    logic accept;
    assign accept = SEND_BYTE & ~byte_sent_q & ~error_q;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            clk_meta    <= 1'b1;
            clk_sync    <= 1'b1;
            clk_prev    <= 1'b1;
            data_meta   <= 1'b1;
            data_sync   <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '1;
            data_bit    <= 1'b1;
            byte_sent_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            clk_meta    <= CLK_MOUSE_IN;
            clk_sync    <= clk_meta;
            clk_prev    <= clk_sync;
            data_meta   <= DATA_MOUSE_IN;
            data_sync   <= data_meta;
            byte_sent_q <= 1'b0;
            error_q     <= 1'b0;

            unique case (state)
                IDLE: begin
                    data_bit <= 1'b1;
                    if (accept) begin
                        shift   <= {1'b1, ~^BYTE_TO_SEND, BYTE_TO_SEND};
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (cnt == INHIBIT_LAST) begin
                        cnt      <= '0;
                        data_bit <= 1'b0;
                        state    <= START;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                START: begin
                    if (cnt == START_LAST) begin
                        cnt   <= '0;
                        state <= SEND;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                SEND: begin
                    // Each device falling edge presents the next frame bit; edge 10 puts out the stop bit.
                    if (fe) begin
                        cnt      <= '0;
                        data_bit <= shift[0];
                        shift    <= {1'b1, shift[9:1]};
                        if (bit_cnt != 4'd10) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (bit_cnt == 4'd9) begin
                            state <= ACK;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt      <= '0;
                        data_bit <= 1'b1;
                        error_q  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ACK: begin
                    if (fe) begin
                        cnt <= '0;
                        if (!data_sync) begin
                            state <= WAIT_IDLE;
                        end else begin
                            error_q <= 1'b1;
                            state   <= IDLE;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt     <= '0;
                        error_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                WAIT_IDLE: begin
                    if (clk_sync && data_sync) begin
                        cnt         <= '0;
                        byte_sent_q <= 1'b1;
                        state       <= IDLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt     <= '0;
                        error_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    data_bit <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign CLK_MOUSE_OUT_EN  = (state == INHIBIT) || (state == START);
    assign DATA_MOUSE_OUT_EN = (state == START) || (state == SEND);
    assign DATA_MOUSE_OUT    = data_bit;
    assign BUSY              = (state != IDLE);
    assign BYTE_SENT         = byte_sent_q;
    assign ERROR             = error_q;
    assign fsm_state         = state;

endmodule

// File: tb/tb_mouse_transmitter.sv
// Bench for mouse_transmitter: PS/2 device model on open-drain pads, expected frames in a queue.
module tb_mouse_transmitter;

    localparam int INHIBIT = 5000;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 20;

    // Handshake: SEND_BYTE is a request sampled on a rising CLK edge only while the
    // transmitter is idle; completion is one BYTE_SENT or ERROR pulse as BUSY falls.

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       send_req = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    logic       clk_pad;
    logic       data_pad;
    logic       clk_en;
    logic       data_out;
    logic       data_en;
    logic       busy;
    logic       byte_sent;
    logic       error;
    logic [2:0] fsm_state;

    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  sent_cnt = 0;
    int  err_cnt = 0;
    int  err_cycle = 0;
    bit  both_seen = 1'b0;

    logic [9:0] exp_q[$];

    // Open-drain pads with pull-ups.
    assign clk_pad  = !(dev_clk_low || clk_en);
    assign data_pad = !(dev_data_low || (data_en && !data_out));

    mouse_transmitter #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK              (clk),
        .RESETN           (resetn),
        .CLK_MOUSE_IN     (clk_pad),
        .DATA_MOUSE_IN    (data_pad),
        .CLK_MOUSE_OUT_EN (clk_en),
        .DATA_MOUSE_OUT   (data_out),
        .DATA_MOUSE_OUT_EN(data_en),
        .SEND_BYTE        (send_req),
        .BYTE_TO_SEND     (byte_in),
        .BUSY             (busy),
        .BYTE_SENT        (byte_sent),
        .ERROR            (error),
        .fsm_state        (fsm_state)
    );

    // Clock / cycle counter / pulse monitor
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_sent === 1'b1) sent_cnt++;
        if (error === 1'b1) begin
            err_cnt++;
            err_cycle = cyc;
        end
        if (byte_sent === 1'b1 && error === 1'b1) both_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic request(input logic [7:0] b, input logic [9:0] frame);
        @(posedge clk); #1;
        send_req = 1'b1;
        byte_in  = b;
        exp_q.push_back(frame);
        @(posedge clk); #1;
        send_req = 1'b0;
        byte_in  = 8'($urandom_range(0, 255));
    endtask

    task automatic measure_hold(output int hold, output int low, output int s_entry,
                                output logic start_bit);
        hold = 0;
        low  = 0;
        @(negedge clk);
        while (clk_en === 1'b1 && hold < 4 * INHIBIT) begin
            hold++;
            if (data_en === 1'b1 && data_out === 1'b0) low++;
            @(negedge clk);
        end
        s_entry   = cyc;
        start_bit = data_pad;
    endtask

    task automatic device_clock(input int n_edges, input bit ack_low, output logic [9:0] rx);
        rx = '0;
        for (int i = 1; i <= n_edges; i++) begin
            if (i == 11 && ack_low) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (HALF) @(posedge clk);
            #1;
            if (i <= 10) rx[i-1] = data_pad;
            dev_clk_low = 1'b0;
            if (i == 11) dev_data_low = 1'b0;
            if (i < 11) begin
                repeat (HALF) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Tests
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({clk_en, data_out, data_en, busy, byte_sent, error} !== 6'b010000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 010000",
                     {clk_en, data_out, data_en, busy, byte_sent, error});
        end
        vectors++;
        if (fsm_state !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected 0", fsm_state);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_send_byte(input logic [7:0] b, input logic [9:0] frame, input string name);
        int hold, low, s, s0, e0;
        logic start_bit;
        logic [9:0] rx;
        logic [9:0] exp;
        s0 = sent_cnt;
        e0 = err_cnt;
        request(b, frame);
        measure_hold(hold, low, s, start_bit);
        repeat (10) @(posedge clk);
        #1;
        device_clock(11, 1'b1, rx);
        wait_idle();
        vectors++;
        if (hold !== INHIBIT + 2) begin
            miscompares++;
            $display("FAIL %s clock_hold: got %0d expected %0d", name, hold, INHIBIT + 2);
        end
        vectors++;
        if (low !== 2 || start_bit !== 1'b0) begin
            miscompares++;
            $display("FAIL %s start_bit: low cycles %0d pad %b expected 2 and 0", name, low, start_bit);
        end
        exp = exp_q.pop_front();
        vectors++;
        if (rx !== exp) begin
            miscompares++;
            $display("FAIL %s frame: got %b expected %b", name, rx, exp);
        end
        vectors++;
        if (rx[8] !== frame[8]) begin
            miscompares++;
            $display("FAIL %s parity: got %b expected %b", name, rx[8], frame[8]);
        end
        vectors++;
        if (sent_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL %s outcome: sent %0d err %0d expected 1 and 0", name, sent_cnt - s0, err_cnt - e0);
        end
        vectors++;
        if ({busy, clk_en, data_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s released: busy/clk_en/data_en %b expected 000", name, {busy, clk_en, data_en});
        end
    endtask

    task automatic test_no_ack();
        int hold, low, s, s0, e0;
        logic start_bit;
        logic [9:0] rx;
        logic [9:0] exp;
        s0 = sent_cnt;
        e0 = err_cnt;
        request(8'h3C, 10'h33C);
        measure_hold(hold, low, s, start_bit);
        repeat (10) @(posedge clk);
        #1;
        device_clock(11, 1'b0, rx);
        wait_idle();
        exp = exp_q.pop_front();
        vectors++;
        if (rx !== exp) begin
            miscompares++;
            $display("FAIL no_ack frame: got %b expected %b", rx, exp);
        end
        vectors++;
        if (err_cnt - e0 !== 1 || sent_cnt - s0 !== 0) begin
            miscompares++;
            $display("FAIL no_ack outcome: err %0d sent %0d expected 1 and 0", err_cnt - e0, sent_cnt - s0);
        end
        vectors++;
        if ({busy, clk_en, data_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL no_ack released: busy/clk_en/data_en %b expected 000", {busy, clk_en, data_en});
        end
    endtask

    task automatic test_timeout();
        int hold, low, s, s0, e0, n;
        logic start_bit;
        s0 = sent_cnt;
        e0 = err_cnt;
        request(8'h5A, 10'h35A);
        measure_hold(hold, low, s, start_bit);
        n = 0;
        while (err_cnt == e0 && n < 3 * TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        void'(exp_q.pop_front());
        vectors++;
        if (err_cnt - e0 !== 1) begin
            miscompares++;
            $display("FAIL timeout pulse: got %0d error pulses expected 1", err_cnt - e0);
        end
        vectors++;
        if (err_cycle - s !== TIMEOUT) begin
            miscompares++;
            $display("FAIL timeout latency: got %0d cycles expected %0d", err_cycle - s, TIMEOUT);
        end
        vectors++;
        if (sent_cnt - s0 !== 0 || {busy, clk_en, data_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL timeout released: sent %0d busy/clk_en/data_en %b expected 0 and 000",
                     sent_cnt - s0, {busy, clk_en, data_en});
        end
    endtask

    task automatic test_back_to_back();
        int hold, low, s, s0, n;
        logic start_bit;
        logic [9:0] rx;
        logic [9:0] exp;
        s0 = sent_cnt;
        request(8'hF4, 10'h2F4);
        measure_hold(hold, low, s, start_bit);
        repeat (10) @(posedge clk);
        #1;
        fork
            device_clock(11, 1'b1, rx);
            begin
                repeat (100) @(posedge clk);
                #1;
                send_req = 1'b1;
                byte_in  = 8'h00;
                @(posedge clk); #1;
                send_req = 1'b0;
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b mid_request: busy %b expected 1", busy);
                end
            end
            begin
                n = 0;
                do begin
                    @(posedge clk); #1;
                    n++;
                end while (byte_sent !== 1'b1 && n < 2000);
                send_req = 1'b1;
                byte_in  = 8'h00;
                @(posedge clk); #1;
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b pulse_cycle_request: busy %b expected 0", busy);
                end
                byte_in = 8'hA5;
                exp_q.push_back(10'h3A5);
                @(posedge clk); #1;
                send_req = 1'b0;
                byte_in  = 8'($urandom_range(0, 255));
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b next_cycle_accept: busy %b expected 1", busy);
                end
            end
        join
        exp = exp_q.pop_front();
        vectors++;
        if (rx !== exp) begin
            miscompares++;
            $display("FAIL b2b first_frame: got %b expected %b", rx, exp);
        end
        measure_hold(hold, low, s, start_bit);
        vectors++;
        if (hold !== INHIBIT + 2) begin
            miscompares++;
            $display("FAIL b2b second_hold: got %0d expected %0d", hold, INHIBIT + 2);
        end
        repeat (10) @(posedge clk);
        #1;
        device_clock(11, 1'b1, rx);
        wait_idle();
        exp = exp_q.pop_front();
        vectors++;
        if (rx !== exp) begin
            miscompares++;
            $display("FAIL b2b second_frame: got %b expected %b", rx, exp);
        end
        vectors++;
        if (sent_cnt - s0 !== 2) begin
            miscompares++;
            $display("FAIL b2b outcome: got %0d BYTE_SENT pulses expected 2", sent_cnt - s0);
        end
    endtask

    task automatic test_reset_mid();
        int hold, low, s, s0, e0;
        logic start_bit;
        logic [9:0] rx;
        request(8'hF4, 10'h2F4);
        measure_hold(hold, low, s, start_bit);
        repeat (10) @(posedge clk);
        #1;
        device_clock(4, 1'b0, rx);
        dev_clk_low = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s0 = sent_cnt;
        e0 = err_cnt;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({clk_en, data_en, busy, byte_sent, error} !== 5'b00000 || fsm_state !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_mid outputs: clk_en/data_en/busy/sent/err %b state %0d expected 00000 and 0",
                     {clk_en, data_en, busy, byte_sent, error}, fsm_state);
        end
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        dev_clk_low = 1'b0;
        void'(exp_q.pop_front());
        repeat (50) @(posedge clk);
        #1;
        vectors++;
        if (sent_cnt - s0 !== 0 || err_cnt - e0 !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid pulses: sent %0d err %0d busy %b expected 0 0 0",
                     sent_cnt - s0, err_cnt - e0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_send_byte(8'hF4, 10'h2F4, "send_f4");
        test_send_byte(8'hFF, 10'h3FF, "send_ff");
        test_no_ack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_send_byte(8'hF4, 10'h2F4, "send_after_reset");
        vectors++;
        if (both_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL exclusive_pulses: BYTE_SENT and ERROR high together, got %b expected 0", both_seen);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
